// File: rtl/cla_multiword_seq_if.sv
// cla_multiword_seq_if: operand request / result response bundle for the
// multi-word CLA sequencer.
//   request : in_valid, in_ready, op_a, op_b, cin (and sub when the subtract
//             option CLA_SEQ_SUB_EN is compiled in)
//   response: out_valid, out_ready, sum, cout, ovf
// Modports: master = operand producer / result consumer, slave = sequencer.
interface cla_multiword_seq_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   op_a;
    logic [16*WORDS-1:0]   op_b;
    logic                  cin;
`ifdef CLA_SEQ_SUB_EN
    logic                  sub;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   sum;
    logic                  cout;
    logic                  ovf;

`ifdef CLA_SEQ_SUB_EN
    modport master (output in_valid, op_a, op_b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, op_a, op_b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, op_a, op_b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, op_a, op_b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: multi-precision adder that streams two 16*WORDS-bit
// operands through one shared 16-bit carry-lookahead adder, LSW first,
// chaining the carry in a register. Latency WORDS+1, one op per WORDS+2.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - cla_multiword_seq_if.slave (request/response handshakes)
// Parameters: WORDS (2..8) words of 16 bits per operand.
// Option macro: CLA_SEQ_SUB_EN adds the sub input (A - B via ~B + 1).

// 4-bit lookahead slice: sum only, group G/P is formed by the parent so the
// carry network has no path back through the slices.
module cla_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum
);
    logic [3:0] g, p, c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c;
endmodule

// Two-level 16-bit CLA: four 4-bit slices plus group carry lookahead.
module CLA_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g, p;
    logic [3:0]  gg, pg;
    logic [4:0]  c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar i = 0; i < 4; i++) begin : g_grp
        assign gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) |
                       (p[4*i+3] & p[4*i+2] & g[4*i+1]) |
                       (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        assign pg[i] = &p[4*i +: 4];
        cla_4_bit u_slice (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .cin (c[i]),
            .sum (sum[4*i +: 4])
        );
    end

    assign c[0] = cin;
    assign c[1] = gg[0] | (pg[0] & cin);
    assign c[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    assign c[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) |
                  (pg[2] & pg[1] & pg[0] & cin);
    assign c[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) |
                  (pg[3] & pg[2] & pg[1] & gg[0]) | ((&pg) & cin);
    assign cout = c[4];
endmodule

module cla_multiword_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    cla_multiword_seq_if.slave bus
);
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic                 in_ready_q, out_valid_q;
    logic [WORDS-1:0][15:0] a_q, b_q, acc_q, acc_nxt, sum_q;
    logic                 carry_q, cout_q, ovf_q;
    logic [KW-1:0]        k_q;
    logic [16*WORDS-1:0]  b_in;
    logic                 c_in;
    logic [15:0]          cla_sum;
    logic                 cla_cout;
    logic                 last;

`ifdef CLA_SEQ_SUB_EN
    // Subtract as A + ~B + 1; the incoming cin is ignored in that mode.
    assign b_in = bus.sub ? ~bus.op_b : bus.op_b;
    assign c_in = bus.sub | bus.cin;
`else
    assign b_in = bus.op_b;
    assign c_in = bus.cin;
`endif

    CLA_16_bit u_cla (
        .a    (a_q[k_q]),
        .b    (b_q[k_q]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign last = (k_q == KW'(WORDS - 1));

    // Partial sum with the current word merged in; becomes the result on
    // the last word so the visible sum only changes on entry to DONE.
    always_comb begin
        acc_nxt      = acc_q;
        acc_nxt[k_q] = cla_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            k_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.op_a;
                        b_q        <= b_in;
                        carry_q    <= c_in;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_nxt;
                    carry_q <= cla_cout;
                    k_q     <= k_q + 1'b1;
                    if (last) begin
                        k_q         <= '0;
                        sum_q       <= acc_nxt;
                        cout_q      <= cla_cout;
                        // Same-sign operands with a different-sign result.
                        ovf_q       <= (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                                       (cla_sum[15] != a_q[WORDS-1][15]);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
